// File: rtl/udc_pkg.sv
// rtl/udc_pkg.sv - shared types and constants for the up/down cycle counter
package udc_pkg;

  // Run phases; a run walks PLR -> ULR -> LLR -> PLR per cycle.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    UP_TO_ULR   = 2'd1,
    DOWN_TO_LLR = 2'd2,
    UP_TO_PLR   = 2'd3
  } udc_state_t;

  // Register map; addresses 5..7 are reserved and read as 0.
  localparam logic [2:0] ADDR_PLR  = 3'd0;
  localparam logic [2:0] ADDR_ULR  = 3'd1;
  localparam logic [2:0] ADDR_LLR  = 3'd2;
  localparam logic [2:0] ADDR_CCR  = 3'd3;
  localparam logic [2:0] ADDR_CTRL = 3'd4;

  // Reset values (ULR resets to all-ones at whatever width it has).
  localparam int PLR_RST = 1;
  localparam int LLR_RST = 0;
  localparam int CCR_RST = 0;

endpackage

// File: rtl/udc_regfile.sv
// rtl/udc_regfile.sv - limit/cycle registers, write lock, read mux and bus driver
//
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   ncs, nrd, nwr   active-low chip select / read / write strobes
//   A, Din          register address and bidirectional data bus
//   busy, err,state run status from the counter, used for the lock and STATUS
//   plr/ulr/llr/ccr current register values
//   stop            CTRL bit0 write strobe, honoured even while busy
module udc_regfile import udc_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CCR_W = 8,
  localparam int DW = (WIDTH > CCR_W) ? WIDTH : CCR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ncs,
  input  logic             nrd,
  input  logic             nwr,
  input  logic [2:0]       A,
  inout  wire  [DW-1:0]    Din,
  input  logic             busy,
  input  logic             err,
  input  udc_state_t       state,
  output logic [WIDTH-1:0] plr,
  output logic [WIDTH-1:0] ulr,
  output logic [WIDTH-1:0] llr,
  output logic [CCR_W-1:0] ccr,
  output logic             stop
);

  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] rdata;

  assign wr_en = !ncs && !nwr;
  // A simultaneous write strobe suppresses the read driver.
  assign rd_en = !ncs && !nrd && nwr;

  // Stop bypasses the write lock; it is the only way to end a run early.
  assign stop = wr_en && (A == ADDR_CTRL) && Din[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      plr <= WIDTH'(PLR_RST);
      ulr <= '1;
      llr <= WIDTH'(LLR_RST);
      ccr <= CCR_W'(CCR_RST);
    end else if (wr_en && !busy) begin
      case (A)
        ADDR_PLR: plr <= Din[WIDTH-1:0];
        ADDR_ULR: ulr <= Din[WIDTH-1:0];
        ADDR_LLR: llr <= Din[WIDTH-1:0];
        ADDR_CCR: ccr <= Din[CCR_W-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (A)
      ADDR_PLR:  rdata = DW'(plr);
      ADDR_ULR:  rdata = DW'(ulr);
      ADDR_LLR:  rdata = DW'(llr);
      ADDR_CCR:  rdata = DW'(ccr);
      ADDR_CTRL: rdata = DW'({busy, err, state});
      default:   rdata = '0;
    endcase
  end

  assign Din = rd_en ? rdata : 'z;

endmodule

// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - bus-programmable cyclic up/down counter top
//
// Optional feature macro: UDC_CONT_MODE_EN (CCR=0 at start runs continuously).
//
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   ncs, nrd, nwr   active-low chip select / read / write strobes
//   A, Din          register address and bidirectional data bus
//   start_in        start request, rising edge sampled on clk
//   cout            current count
//   dir             1 while the active leg counts up
//   err             registered limit error (LLR>PLR or PLR>ULR)
//   ec              one-clock end-of-cycles pulse
//   busy            run in progress
module up_down_counter_param import udc_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CCR_W = 8,
  localparam int DW = (WIDTH > CCR_W) ? WIDTH : CCR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ncs,
  input  logic             nrd,
  input  logic             nwr,
  input  logic [2:0]       A,
  inout  wire  [DW-1:0]    Din,
  input  logic             start_in,
  output logic [WIDTH-1:0] cout,
  output logic             dir,
  output logic             err,
  output logic             ec,
  output logic             busy
);

`ifdef UDC_CONT_MODE_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  udc_state_t       state, state_n, leg;
  logic [WIDTH-1:0] plr, ulr, llr, cout_n;
  logic [CCR_W-1:0] ccr, rem, rem_n;
  logic             cont, cont_n;
  logic             ec_n, stop, start_q, start_go, cyc_end;

  udc_regfile #(.WIDTH(WIDTH), .CCR_W(CCR_W)) u_regs (
    .clk   (clk),
    .reset (reset),
    .ncs   (ncs),
    .nrd   (nrd),
    .nwr   (nwr),
    .A     (A),
    .Din   (Din),
    .busy  (busy),
    .err   (err),
    .state (state),
    .plr   (plr),
    .ulr   (ulr),
    .llr   (llr),
    .ccr   (ccr),
    .stop  (stop)
  );

  assign busy     = (state != IDLE);
  assign dir      = (state == UP_TO_ULR) || (state == UP_TO_PLR);
  assign start_go = start_in && !start_q && !ncs && !err && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cout    <= '0;
      rem     <= '0;
      cont    <= 1'b0;
      ec      <= 1'b0;
      err     <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      cout    <= cout_n;
      rem     <= rem_n;
      cont    <= cont_n;
      ec      <= ec_n;
      err     <= (llr > plr) || (plr > ulr);
      start_q <= start_in;
    end
  end

  always_comb begin
    state_n = state;
    cout_n  = cout;
    rem_n   = rem;
    cont_n  = cont;
    ec_n    = 1'b0;
    leg     = state;
    cyc_end = 1'b0;

    if (state == IDLE) begin
      if (start_go) begin
        if (ccr == '0 && !CONT_EN) begin
          ec_n = 1'b1;
        end else begin
          cout_n  = plr;
          rem_n   = ccr;
          cont_n  = (ccr == '0);
          state_n = UP_TO_ULR;
        end
      end
    end else if (stop || err) begin
      state_n = IDLE;
    end else begin
      // Legs whose endpoint is already reached cost no clock.
      if (leg == UP_TO_ULR && cout == ulr) leg = DOWN_TO_LLR;
      if (leg == DOWN_TO_LLR && cout == llr) leg = UP_TO_PLR;

      if (leg == UP_TO_PLR && cout == plr) begin
        // Only reachable when all three limits are equal.
        cyc_end = 1'b1;
      end else begin
        state_n = leg;
        case (leg)
          UP_TO_ULR: begin
            cout_n = cout + WIDTH'(1);
            if (cout_n == ulr) state_n = DOWN_TO_LLR;
          end
          DOWN_TO_LLR: begin
            cout_n = cout - WIDTH'(1);
            if (cout_n == llr) begin
              state_n = UP_TO_PLR;
              cyc_end = (llr == plr);
            end
          end
          default: begin
            cout_n  = cout + WIDTH'(1);
            cyc_end = (cout_n == plr);
          end
        endcase
      end

      if (cyc_end) begin
        state_n = UP_TO_ULR;
        if (!cont) begin
          rem_n = rem - CCR_W'(1);
          if (rem == CCR_W'(1)) begin
            ec_n    = 1'b1;
            state_n = IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb/tb_up_down_counter_param.sv - self-checking bench for up_down_counter_param
module tb_up_down_counter_param;
  import udc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ncs = 1'b1, nrd = 1'b1, nwr = 1'b1, start_in = 1'b0;
  logic [2:0] A = 3'd0;
  logic       drv_en = 1'b0;
  logic [7:0] drv_data = 8'd0;
  wire  [7:0] Din;
  logic [7:0] cout;
  logic       dir, err, ec, busy;
  logic [7:0] rd;
  int         n_checks = 0;
  int         n_pass = 0;

  assign Din = drv_en ? drv_data : 'z;

  up_down_counter_param #(.WIDTH(8), .CCR_W(8)) dut (
    .clk(clk), .reset(reset), .ncs(ncs), .nrd(nrd), .nwr(nwr), .A(A),
    .Din(Din), .start_in(start_in), .cout(cout), .dir(dir), .err(err),
    .ec(ec), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {bit we; logic [2:0] a; logic [7:0] d;} reg_vec_t;
  typedef struct {logic [7:0] c; bit b; bit e; bit d;} trace_t;
  reg_vec_t rtab[$];
  trace_t   ttab[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    A = a; drv_data = d; drv_en = 1'b1; ncs = 1'b0; nwr = 1'b0;
    tick();
    nwr = 1'b1; ncs = 1'b1; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    A = a; ncs = 1'b0; nrd = 1'b0;
    #1;
    d = Din;
    nrd = 1'b1; ncs = 1'b1;
    #1;
  endtask

  task automatic do_start();
    ncs = 1'b0; start_in = 1'b1;
    tick();
    start_in = 1'b0; ncs = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      tick();
    end
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Expected trace built from the cycle definition: each cycle walks
  // PLR->ULR, ULR->LLR, LLR->PLR one unit per clock without repeating
  // endpoints; an all-equal set costs one held clock per cycle.
  task automatic run_model(input string tag, input int plr, input int ulr, input int llr, input int ccr);
    int vals[$];
    bit bnd[$];
    int cyc[$];
    bit last, edir;
    vals.push_back(plr); bnd.push_back(1'b1);
    for (int c = 0; c < ccr; c++) begin
      cyc.delete();
      if (plr == ulr && ulr == llr) cyc.push_back(plr);
      else begin
        for (int v = plr + 1; v <= ulr; v++) cyc.push_back(v);
        for (int v = ulr - 1; v >= llr; v--) cyc.push_back(v);
        for (int v = llr + 1; v <= plr; v++) cyc.push_back(v);
      end
      for (int i = 0; i < cyc.size(); i++) begin
        vals.push_back(cyc[i]);
        bnd.push_back(i == cyc.size() - 1);
      end
    end
    do_start();
    for (int i = 0; i < vals.size(); i++) begin
      last = (i == vals.size() - 1);
      edir = last ? 1'b0 : (bnd[i] ? 1'b1 : (vals[i+1] > vals[i]));
      if (i > 0) tick();
      check($sformatf("%s step %0d {cout,busy,ec,dir}", tag, i),
            {21'd0, cout, busy, ec, dir}, {21'd0, 8'(vals[i]), !last, last, edir});
    end
    tick();
    check({tag, " after {busy,ec}"}, {30'd0, busy, ec}, 32'd0);
  endtask

  initial begin
    int l, p, u, c, k;
    bit bad, exp_err, ec_seen;
    int cont_seq[6];

    // Register map: reset values, reserved address, write/readback.
    rtab.push_back('{0, ADDR_PLR, 8'd1});   rtab.push_back('{0, ADDR_ULR, 8'd255});
    rtab.push_back('{0, ADDR_LLR, 8'd0});   rtab.push_back('{0, ADDR_CCR, 8'd0});
    rtab.push_back('{0, ADDR_CTRL, 8'd0});  rtab.push_back('{0, 3'd5, 8'd0});
    rtab.push_back('{1, ADDR_PLR, 8'd2});   rtab.push_back('{0, ADDR_PLR, 8'd2});
    rtab.push_back('{1, ADDR_ULR, 8'd4});   rtab.push_back('{0, ADDR_ULR, 8'd4});
    rtab.push_back('{1, ADDR_LLR, 8'd1});   rtab.push_back('{0, ADDR_LLR, 8'd1});
    rtab.push_back('{1, ADDR_CCR, 8'd1});   rtab.push_back('{0, ADDR_CCR, 8'd1});
    // PLR=2 ULR=4 LLR=1 CCR=1 run, starting at the start edge.
    ttab.push_back('{8'd2, 1, 0, 1}); ttab.push_back('{8'd3, 1, 0, 1});
    ttab.push_back('{8'd4, 1, 0, 0}); ttab.push_back('{8'd3, 1, 0, 0});
    ttab.push_back('{8'd2, 1, 0, 0}); ttab.push_back('{8'd1, 1, 0, 1});
    ttab.push_back('{8'd2, 0, 1, 0}); ttab.push_back('{8'd2, 0, 0, 0});

    reset = 1'b0;
    tick(); tick();
    check("reset outputs", {20'd0, cout, dir, err, ec, busy}, 32'd0);
    reset = 1'b1;
    tick();
    check("post-reset outputs", {20'd0, cout, dir, err, ec, busy}, 32'd0);

    foreach (rtab[i]) begin
      if (rtab[i].we) bus_write(rtab[i].a, rtab[i].d);
      else begin
        bus_read(rtab[i].a, rd);
        check($sformatf("reg read %0d addr %0d", i, rtab[i].a), {24'd0, rd}, {24'd0, rtab[i].d});
      end
    end
    tick();
    check("err valid limits", {31'd0, err}, 32'd0);

    do_start();
    for (int i = 0; i < ttab.size(); i++) begin
      if (i > 0) tick();
      check($sformatf("trace %0d {cout,busy,ec,dir}", i), {21'd0, cout, busy, ec, dir},
            {21'd0, ttab[i].c, ttab[i].b, ttab[i].e, ttab[i].d});
    end

    bus_write(ADDR_CCR, 8'd2);
    tick();
    run_model("ccr2", 2, 4, 1, 2);

    // Writes while busy are dropped; STATUS reflects the run.
    bus_write(ADDR_CCR, 8'd1);
    tick();
    do_start();
    bus_write(ADDR_PLR, 8'd9);
    bus_read(ADDR_PLR, rd);
    check("locked PLR write", {24'd0, rd}, 32'd2);
    bus_read(ADDR_CTRL, rd);
    check("status mid-run", {24'd0, rd}, 32'h9);
    wait_idle("locked");

    // Limit error blocks start.
    bus_write(ADDR_ULR, 8'd255);
    bus_write(ADDR_PLR, 8'd5);
    tick();
    check("err PLR=5", {31'd0, err}, 32'd0);
    bus_write(ADDR_LLR, 8'd6);
    check("err not early", {31'd0, err}, 32'd0);
    tick();
    check("err LLR>PLR", {31'd0, err}, 32'd1);
    bus_read(ADDR_CTRL, rd);
    check("status err", {24'd0, rd}, 32'h4);
    do_start();
    check("start with err {busy,ec}", {30'd0, busy, ec}, 32'd0);
    tick();
    check("start with err later", {30'd0, busy, ec}, 32'd0);
    bus_write(ADDR_LLR, 8'd1);
    bus_write(ADDR_PLR, 8'd2);
    bus_write(ADDR_ULR, 8'd4);
    tick();
    check("err cleared", {31'd0, err}, 32'd0);

    // CCR=0 start.
    bus_write(ADDR_CCR, 8'd0);
    tick();
    do_start();
`ifdef UDC_CONT_MODE_EN
    check("cont start {busy,cout}", {23'd0, busy, cout}, {23'd0, 1'b1, 8'd2});
    cont_seq = '{3, 4, 3, 2, 1, 2};
    ec_seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ec) ec_seen = 1'b1;
    end
    check("cont count", {24'd0, cout}, 32'(cont_seq[19 % 6]));
    bus_write(ADDR_CTRL, 8'd1);
    check("cont stop {busy,ec,cout}", {22'd0, busy, ec, cout}, {22'd0, 2'b00, 8'(cont_seq[19 % 6])});
    check("cont no ec", {31'd0, ec_seen}, 32'd0);
    tick();
    check("cont stopped hold", {23'd0, busy, cout}, {23'd0, 1'b0, 8'(cont_seq[19 % 6])});
`else
    check("ccr0 {busy,ec,cout}", {22'd0, busy, ec, cout}, {22'd0, 2'b01, 8'd2});
    tick();
    check("ccr0 ec one clock", {30'd0, busy, ec}, 32'd0);
`endif

    // Mid-run reset.
    bus_write(ADDR_CCR, 8'd1);
    tick();
    do_start();
    tick(); tick();
    bus_read(ADDR_CTRL, rd);
    check("status down leg", {24'd0, rd}, 32'hA);
    reset = 1'b0;
    tick();
    check("mid reset {cout,busy,ec}", {22'd0, cout, busy, ec}, 32'd0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus_read(rtab[i].a, rd);
      check($sformatf("post-reset reg %0d", i), {24'd0, rd}, {24'd0, rtab[i].d});
    end

    // All limits equal.
    bus_write(ADDR_PLR, 8'd7);
    bus_write(ADDR_ULR, 8'd7);
    bus_write(ADDR_LLR, 8'd7);
    bus_write(ADDR_CCR, 8'd3);
    tick();
    run_model("flat", 7, 7, 7, 3);

    // start_in held high does not retrigger.
    bus_write(ADDR_CCR, 8'd1);
    tick();
    ncs = 1'b0; start_in = 1'b1;
    tick();
    check("held start first", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("held start %0d", i), {31'd0, busy}, 32'd0);
    end
    start_in = 1'b0; ncs = 1'b1;
    tick();

    // Randomized limit sets against the reference trace.
    for (int it = 0; it < 20; it++) begin
      bad = ($urandom_range(0, 4) == 0);
      if (bad) begin
        l = $urandom_range(3, 8);
        p = l - $urandom_range(1, 3);
      end else begin
        l = $urandom_range(0, 5);
        p = l + $urandom_range(0, 4);
      end
      u = p + $urandom_range(0, 4);
      c = $urandom_range(1, 3);
      bus_write(ADDR_PLR, 8'(p));
      bus_write(ADDR_ULR, 8'(u));
      bus_write(ADDR_LLR, 8'(l));
      bus_write(ADDR_CCR, 8'(c));
      tick();
      exp_err = (l > p) || (p > u);
      check($sformatf("rand %0d err", it), {31'd0, err}, {31'd0, exp_err});
      if (exp_err) begin
        do_start();
        check($sformatf("rand %0d blocked", it), {30'd0, busy, ec}, 32'd0);
      end else begin
        run_model($sformatf("rand %0d", it), p, u, l, c);
      end
    end

    k = n_checks;
    $display("%0d/%0d checks passed", n_pass, k);
    $finish;
  end

endmodule

// File: doc/up_down_counter_param.md
# up_down_counter_param

Parametrised, bus-programmable cyclic up/down counter. It is the WIDTH-generic successor of the 8-bit cyclic counter and adds a clean FSM, a write lock while running, a readable status/control register, a software stop, and an optional continuous mode. Software programs preload (PLR), upper (ULR) and lower (LLR) limits and cycle count (CCR) over the chip-select bus. Each `start_in` pulse then runs CCR cycles of PLR→ULR→LLR→PLR, and `ec` flags completion.

## Interface
- `WIDTH`, 8, width of the count and of the PLR/ULR/LLR registers.
- `CCR_W`, 8, width of CCR and of the remaining-cycle counter.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `ncs`  in  1  chip select, active-low; gates bus access and start.
- `nrd`  in  1  read strobe, active-low.
- `nwr`  in  1  write strobe, active-low.
- `A`  in  3  register address: 0 PLR, 1 ULR, 2 LLR, 3 CCR, 4 CTRL/STATUS, 5–7 reserved.
- `Din`  inout  max(WIDTH,CCR_W)  data bus; driven only while ncs=0, nrd=0, nwr=1; high-Z otherwise.
- `start_in`  in  1  start request; a rising edge is sampled on `clk`.
- `cout`  out  WIDTH  current count.
- `dir`  out  1  1 = counting up, 0 = counting down or idle.
- `err`  out  1  limit error: LLR>PLR or PLR>ULR.
- `ec`  out  1  end-of-cycles pulse, one clock wide.
- `busy`  out  1  FSM not IDLE.

## Operation
- Reset values: PLR=1, ULR=all-ones, LLR=0, CCR=0. Outputs: cout=0, dir=0, err=0, ec=0, busy=0. FSM goes to IDLE and the Din driver is off.
- Writes take effect at a clock edge with ncs=0 and nwr=0. They are accepted only in IDLE; while busy they are silently dropped. If nwr and nrd are both low, the write wins and Din stays undriven.
- Reads are allowed in any state; unused upper bits read 0.
  - STATUS read layout: {busy, err, state[1:0]}.
  - CTRL write bit0=1 is a stop: the FSM aborts to IDLE, no ec, and cout holds its value.
- `err` is registered from the current register values every clock.
  - A start with err=1 is ignored.
  - If err goes to 1 while busy, the run aborts to IDLE with no ec.
- FSM states: IDLE, UP_TO_ULR, DOWN_TO_LLR, UP_TO_PLR.
- Start is accepted on a start_in rising edge with ncs=0, err=0 and state IDLE.
  - If CCR=0: ec=1 for one clock and the FSM stays IDLE.
  - Otherwise: cout←PLR, remaining←CCR, state←UP_TO_ULR, busy=1, dir=1.
  - If a write and a start fall on the same edge, the write is accepted and the start uses the pre-write register values.
- Counting moves cout by exactly 1 per clock. A limit value is never repeated at a turn-around. A leg whose endpoint already equals cout is skipped in zero clocks.
- One cycle is PLR→ULR→LLR→PLR, lasting (ULR−PLR)+(ULR−LLR)+(PLR−LLR) clocks.
- On the clock where cout reaches PLR in UP_TO_PLR, remaining decrements.
  - If the result is 0: ec=1 for one clock, state←IDLE, dir=0, and cout holds PLR.
  - Otherwise the next clock continues upward (cout=PLR+1) in UP_TO_ULR.
- Degenerate case PLR=ULR=LLR: each cycle consumes one clock with cout held; ec fires after CCR clocks.
- Arithmetic is unsigned and never wraps, because cout is always kept between LLR and ULR.

## Timing
- Start latency: start_in is sampled low at edge N−1 and high at edge N. At edge N, busy=1 and cout=PLR; the first step happens at edge N+1.
- ec is asserted on the same edge at which cout returns to PLR for the final time, and busy drops on that same edge.
- start_in held high does not retrigger; it needs a new low→high edge.
- Reset low at any edge overrides everything, including a mid-run count.
- ncs=1 during a run does not pause counting; it only blocks bus access and new starts.

## Configuration
- `UDC_CONT_MODE_EN` defined: CCR=0 at start means run continuously. remaining never decrements, ec never fires, and only a stop, err or reset ends the run.
- `UDC_CONT_MODE_EN` undefined: CCR=0 at start gives an immediate one-clock ec and no counting.

## Structure
- Package `udc_pkg` holds:
  - the state enum (IDLE, UP_TO_ULR, DOWN_TO_LLR, UP_TO_PLR);
  - the address constants (ADDR_PLR … ADDR_CTRL);
  - the reset constants (PLR_RST=1, LLR_RST=0, CCR_RST=0).
- Sub-module `udc_regfile` holds the register file, write lock, read mux and Din tristate, and receives `busy` from the top. The top holds the FSM, the counter, err and ec.

## Test plan
- WIDTH=8, PLR=2, ULR=4, LLR=1, CCR=1, start → cout 2,3,4,3,2,1,2 on consecutive clocks; ec=1 on the final 2; dir 1,1,0,0,0,1.
- Same limits with CCR=2 → a 12-clock run with no repeated value at the cycle boundary (…,1,2,3,…); ec exactly once.
- PLR=5, LLR=6 → err=1 next clock; start ignored, busy stays 0. A write to PLR while busy is dropped and reads back the old value.
- CCR=0 start → one-clock ec with busy=0 (macro off); with `UDC_CONT_MODE_EN`, the count runs until CTRL bit0=1 stops it with no ec.
- Mid-run reset=0 → next clock cout=0, busy=0, and registers back to 1/255/0/0.
- PLR=ULR=LLR=7, CCR=3 → cout held at 7; ec on the 3rd clock after start.
